// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invdly_cal.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__invdly_cal
//
// Calibration controller for a tapped inv_2 delay line. The delay line is closed
// into a ring oscillator. The controller counts ring edges over a fixed window
// of CLK cycles. It then walks the tap select one step at a time until the
// measured count crosses the programmed target.
//
// Ports
//   CLK     in             sole clock, rising edge
//   RN      in             asynchronous active-low reset
//   START   in             single-cycle calibration request (ignored while BUSY)
//   TARGET  in  [CNT_W]    desired edges per window, latched on accepted START
//   OSC     in             ring output, asynchronous, 2-flop synchronized here
//   RO_EN   out            ring oscillator enable
//   TAP     out [TAP_W]    tap select (higher tap = slower ring)
//   BUSY    out            search in progress
//   DONE    out            search finished, held until the next accepted START
//   ERR     out            search ran off the tap range (valid with DONE)
//   COUNT   out [CNT_W]    edge count of the last completed window
//
// Build option
//   GF180MCU_FD_SC_MCU7T5V0__INVDLY_CAL_TRACK_EN
//     When defined, a successful lock keeps the ring running. Each window nudges
//     TAP by one step whenever the count leaves TARGET +/- HYST. When undefined,
//     DONE is static and HYST has no effect.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__invdly_cal #(
    parameter int TAP_W  = 5,
    parameter int CNT_W  = 12,
    parameter int WIN    = 256,
    parameter int SETTLE = 8,
    parameter int HYST   = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [CNT_W-1:0] TARGET,
    input  logic             OSC,
    output logic             RO_EN,
    output logic [TAP_W-1:0] TAP,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] COUNT
);

`ifdef GF180MCU_FD_SC_MCU7T5V0__INVDLY_CAL_TRACK_EN
    localparam logic TRACK_EN = 1'b1;
`else
    localparam logic TRACK_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int SET_W = $clog2(SETTLE) + 1;
    localparam int WIN_W = $clog2(WIN);

    localparam logic [TAP_W-1:0] TAP_MAX = '1;
    localparam logic [TAP_W-1:0] TAP_RST = TAP_W'(1) << (TAP_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state_reg;
    logic [TAP_W-1:0] tap_reg;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] edge_cnt_reg;
    logic [CNT_W-1:0] count_reg;
    logic [SET_W-1:0] settle_cnt_reg;
    logic [WIN_W-1:0] win_cnt_reg;
    logic             dir_up_reg;
    logic             dir_dn_reg;
    logic             tracking_reg;
    logic             ro_en_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic             osc_s1_reg;
    logic             osc_s2_reg;
    logic             osc_d_reg;

    logic             osc_rise;
    logic [CNT_W:0]   hi_bound;
    logic [CNT_W-1:0] lo_bound;
    logic             too_fast;
    logic             too_slow;
    logic             step_up;
    logic             step_dn;
    logic             lock;
    logic             fail;

    assign osc_rise = osc_s2_reg & ~osc_d_reg;

    // Decision taken in COMPARE. The search locks on the first tap past the
    // crossing, which is detected as a reversal of the step direction.
    always_comb begin
        hi_bound = {1'b0, target_reg} + (CNT_W+1)'(HYST);
        lo_bound = (target_reg > CNT_W'(HYST)) ? target_reg - CNT_W'(HYST) : '0;
        too_fast = {1'b0, edge_cnt_reg} > hi_bound;
        too_slow = edge_cnt_reg < lo_bound;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        lock     = 1'b0;
        fail     = 1'b0;
        if (tracking_reg) begin
            if (too_fast && tap_reg != TAP_MAX) begin
                step_up = 1'b1;
            end else if (too_slow && tap_reg != '0) begin
                step_dn = 1'b1;
            end
        end else if (edge_cnt_reg == target_reg) begin
            lock = 1'b1;
        end else if (edge_cnt_reg > target_reg) begin
            if (dir_dn_reg)             lock    = 1'b1;
            else if (tap_reg == TAP_MAX) fail   = 1'b1;
            else                         step_up = 1'b1;
        end else begin
            if (dir_up_reg)             lock    = 1'b1;
            else if (tap_reg == '0)     fail    = 1'b1;
            else                        step_dn = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg      <= ST_IDLE;
            tap_reg        <= TAP_RST;
            target_reg     <= '0;
            edge_cnt_reg   <= '0;
            count_reg      <= '0;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            dir_up_reg     <= 1'b0;
            dir_dn_reg     <= 1'b0;
            tracking_reg   <= 1'b0;
            ro_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            osc_s1_reg     <= 1'b0;
            osc_s2_reg     <= 1'b0;
            osc_d_reg      <= 1'b0;
        end else begin
            osc_s1_reg <= OSC;
            osc_s2_reg <= osc_s1_reg;
            osc_d_reg  <= osc_s2_reg;

            // BUSY is low in IDLE, DONE and while tracking, so a START there
            // always restarts a full search from the current tap.
            if (START && !busy_reg) begin
                target_reg     <= TARGET;
                done_reg       <= 1'b0;
                err_reg        <= 1'b0;
                dir_up_reg     <= 1'b0;
                dir_dn_reg     <= 1'b0;
                tracking_reg   <= 1'b0;
                busy_reg       <= 1'b1;
                ro_en_reg      <= 1'b1;
                settle_cnt_reg <= '0;
                state_reg      <= ST_SETTLE;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_reg == SET_W'(SETTLE - 1)) begin
                            edge_cnt_reg <= '0;
                            win_cnt_reg  <= '0;
                            state_reg    <= ST_MEASURE;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (osc_rise && edge_cnt_reg != CNT_MAX) begin
                            edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
                        end
                        if (win_cnt_reg == WIN_W'(WIN - 1)) begin
                            state_reg <= ST_COMPARE;
                        end else begin
                            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                        end
                    end
                    ST_COMPARE: begin
                        count_reg <= edge_cnt_reg;
                        if (step_up || step_dn) begin
                            tap_reg        <= step_up ? tap_reg + TAP_W'(1)
                                                      : tap_reg - TAP_W'(1);
                            dir_up_reg     <= step_up;
                            dir_dn_reg     <= step_dn;
                            settle_cnt_reg <= '0;
                            state_reg      <= ST_SETTLE;
                        end else if (fail) begin
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            ro_en_reg <= 1'b0;
                            state_reg <= ST_DONE;
                        end else if (lock && !TRACK_EN) begin
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b0;
                            busy_reg  <= 1'b0;
                            ro_en_reg <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            // Locked with tracking, or tracking inside the dead
                            // band: keep the ring running, next window at once.
                            done_reg     <= 1'b1;
                            err_reg      <= 1'b0;
                            busy_reg     <= 1'b0;
                            tracking_reg <= 1'b1;
                            edge_cnt_reg <= '0;
                            win_cnt_reg  <= '0;
                            state_reg    <= ST_MEASURE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign RO_EN = ro_en_reg;
    assign TAP   = tap_reg;
    assign BUSY  = busy_reg;
    assign DONE  = done_reg;
    assign ERR   = err_reg;
    assign COUNT = count_reg;

endmodule
